// File: rtl/fanout_pkg.sv
// Shared types, default sizing and the acceptance reduction for the broadcast fork.
package fanout_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } fork_state_t;

  localparam int DEF_NUM_OUT    = 3;
  localparam int DEF_DATA_WIDTH = 17;
  localparam int DEF_CNT_WIDTH  = 16;
  localparam int MAX_OUT        = 8;

  // True when every enabled branch has either taken the token or is taking it now.
  // Narrower callers zero-extend; a zero mask bit counts as satisfied.
  function automatic logic all_accepted(input logic [MAX_OUT-1:0] mask,
                                        input logic [MAX_OUT-1:0] done,
                                        input logic [MAX_OUT-1:0] ready);
    return &(~mask | done | ready);
  endfunction

endpackage

// File: rtl/fanout_tok_counter.sv
// Saturating event counter; clear wins over increment, no backpressure.
module fanout_tok_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 inc_i,
  input  logic                 clr_i,
  output logic [CNT_WIDTH-1:0] cnt_o
);

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {CNT_WIDTH{1'b1}})) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/fanout_fork_ctrl.sv
// Eager ready/valid fork of one producer to NUM_OUT consumers with boundary-aligned mask updates.
// Zero-latency combinational handshake; upstream stalls until every enabled branch has taken the token.
module fanout_fork_ctrl
  import fanout_pkg::*;
#(
  parameter int NUM_OUT    = DEF_NUM_OUT,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          in_valid,
  input  logic [DATA_WIDTH-1:0]         in_data,
  output logic                          in_ready,
  output logic [NUM_OUT-1:0]            out_valid,
  output logic [NUM_OUT*DATA_WIDTH-1:0] out_data,
  input  logic [NUM_OUT-1:0]            out_ready,
  input  logic                          cfg_wr,
  input  logic [NUM_OUT-1:0]            cfg_mask,
  output logic                          cfg_pending,
  output logic [NUM_OUT-1:0]            active_mask,
  input  logic                          cnt_clr,
  output logic [NUM_OUT*CNT_WIDTH-1:0]  tok_cnt
);

  logic [NUM_OUT-1:0] done_q, done_d;
  logic [NUM_OUT-1:0] active_q, active_d;
  logic [NUM_OUT-1:0] pend_q, pend_d;
  logic               pending_q, pending_d;
  fork_state_t        state_q, state_d;

  logic [NUM_OUT-1:0] fire;
  logic               complete;
  logic               boundary;

  assign out_data  = {NUM_OUT{in_data}};
  assign out_valid = {NUM_OUT{in_valid}} & active_q & ~done_q;
  assign in_ready  = all_accepted(MAX_OUT'(active_q), MAX_OUT'(done_q), MAX_OUT'(out_ready));
  assign fire      = out_valid & out_ready;
  assign complete  = in_valid & in_ready;

  // A mask may only change where no token is partially delivered.
  assign boundary  = complete | ((state_q == IDLE) & ~in_valid);

  always_comb begin
    done_d    = complete ? '0 : (done_q | fire);
    state_d   = (done_d != '0) ? BUSY : IDLE;
    active_d  = active_q;
    pend_d    = pend_q;
    pending_d = pending_q;
    if (cfg_wr) begin
      if (boundary) begin
        active_d  = cfg_mask;
        pending_d = 1'b0;
      end else begin
        pend_d    = cfg_mask;
        pending_d = 1'b1;
      end
    end else if (pending_q && boundary) begin
      active_d  = pend_q;
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      done_q    <= '0;
      active_q  <= '1;
      pend_q    <= '0;
      pending_q <= 1'b0;
      state_q   <= IDLE;
    end else begin
      done_q    <= done_d;
      active_q  <= active_d;
      pend_q    <= pend_d;
      pending_q <= pending_d;
      state_q   <= state_d;
    end
  end

  assign cfg_pending = pending_q;
  assign active_mask = active_q;

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_cnt
    fanout_tok_counter #(
      .CNT_WIDTH(CNT_WIDTH)
    ) u_cnt (
      .clk_i(CLK),
      .rst_i(RESET),
      .inc_i(fire[g]),
      .clr_i(cnt_clr),
      .cnt_o(tok_cnt[g*CNT_WIDTH +: CNT_WIDTH])
    );
  end

endmodule

// File: tb/tb_fanout_fork_ctrl.sv
// Bench for fanout_fork_ctrl: directed vector table, saturation run, then randomized traffic against a token-level model.
module tb_fanout_fork_ctrl;

  localparam int N  = 3;
  localparam int DW = 17;
  localparam int CW = 16;
  localparam int SW = 4;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic [N-1:0]  out_valid;
  logic [N*DW-1:0] out_data;
  logic [N-1:0]  out_ready;
  logic          cfg_wr;
  logic [N-1:0]  cfg_mask;
  logic          cfg_pending;
  logic [N-1:0]  active_mask;
  logic          cnt_clr;
  logic [N*CW-1:0] tok_cnt;

  logic          s_in_ready;
  logic [N-1:0]  s_out_valid;
  logic [N*DW-1:0] s_out_data;
  logic          s_cfg_pending;
  logic [N-1:0]  s_active_mask;
  logic [N*SW-1:0] s_tok_cnt;

  always #5 CLK = ~CLK;

  fanout_fork_ctrl #(.NUM_OUT(N), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) u_dut (
    .CLK(CLK), .RESET(RESET), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .cfg_wr(cfg_wr),
    .cfg_mask(cfg_mask), .cfg_pending(cfg_pending), .active_mask(active_mask),
    .cnt_clr(cnt_clr), .tok_cnt(tok_cnt)
  );

  fanout_fork_ctrl #(.NUM_OUT(N), .DATA_WIDTH(DW), .CNT_WIDTH(SW)) u_sat (
    .CLK(CLK), .RESET(RESET), .in_valid(in_valid), .in_data(in_data), .in_ready(s_in_ready),
    .out_valid(s_out_valid), .out_data(s_out_data), .out_ready(out_ready), .cfg_wr(cfg_wr),
    .cfg_mask(cfg_mask), .cfg_pending(s_cfg_pending), .active_mask(s_active_mask),
    .cnt_clr(cnt_clr), .tok_cnt(s_tok_cnt)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Token-level model: which branches still owe the current token, and plain integer counts.
  logic [N-1:0] m_taken;
  logic [N-1:0] m_en;
  logic [N-1:0] m_pm;
  bit           m_pend;
  int           m_cnt[N];

  function automatic int sat(input int c, input int w);
    int lim = (1 << w) - 1;
    return (c > lim) ? lim : c;
  endfunction

  function automatic logic [N-1:0] exp_ov();
    logic [N-1:0] v = '0;
    for (int i = 0; i < N; i++) v[i] = in_valid && m_en[i] && !m_taken[i];
    return v;
  endfunction

  function automatic bit exp_ir();
    int owed = 0;
    int rdy  = 0;
    for (int i = 0; i < N; i++) begin
      if (m_en[i] && !m_taken[i]) begin
        owed++;
        if (out_ready[i]) rdy++;
      end
    end
    return owed == rdy;
  endfunction

  task automatic model_step();
    bit accepted, boundary;
    logic [N-1:0] ov;
    if (RESET) begin
      m_taken = '0; m_en = '1; m_pm = '0; m_pend = 0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      return;
    end
    ov       = exp_ov();
    accepted = in_valid && exp_ir();
    boundary = accepted || (m_taken == '0 && !in_valid);
    for (int i = 0; i < N; i++) begin
      if (cnt_clr) m_cnt[i] = 0;
      else if (ov[i] && out_ready[i]) m_cnt[i]++;
      if (ov[i] && out_ready[i]) m_taken[i] = 1'b1;
    end
    if (accepted) m_taken = '0;
    if (cfg_wr) begin
      if (boundary) begin m_en = cfg_mask; m_pend = 0; end
      else begin m_pm = cfg_mask; m_pend = 1; end
    end else if (m_pend && boundary) begin
      m_en = m_pm; m_pend = 0;
    end
  endtask

  task automatic drive(input bit r, input bit iv, input logic [DW-1:0] d, input logic [N-1:0] rdy,
                       input bit cw, input logic [N-1:0] cm, input bit clr);
    RESET = r; in_valid = iv; in_data = d; out_ready = rdy;
    cfg_wr = cw; cfg_mask = cm; cnt_clr = clr;
  endtask

  task automatic finish_cycle();
    model_step();
    @(posedge CLK);
    #1;
  endtask

  typedef struct {
    bit           rst, iv, cw, clr;
    logic [DW-1:0] dat;
    logic [N-1:0] rdy, cm;
    bit           e_ir, e_pend;
    logic [N-1:0] e_ov, e_am;
    int           c[N];
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input bit r, input bit iv, input logic [DW-1:0] d, input logic [N-1:0] rdy,
                              input bit cw, input logic [N-1:0] cm, input bit clr, input bit ir,
                              input logic [N-1:0] ov, input logic [N-1:0] am, input bit pd,
                              input int c0, input int c1, input int c2);
    vec_t v;
    v.rst = r; v.iv = iv; v.dat = d; v.rdy = rdy; v.cw = cw; v.cm = cm; v.clr = clr;
    v.e_ir = ir; v.e_ov = ov; v.e_am = am; v.e_pend = pd;
    v.c[0] = c0; v.c[1] = c1; v.c[2] = c2;
    return v;
  endfunction

  initial begin
    // broadcast, staggered accept, config while busy
    tbl.push_back(mk(0,1,'h1A5,3'b111,0,0,0, 1,3'b111,3'b111,0, 0,0,0));
    tbl.push_back(mk(0,1,'h0F0,3'b001,0,0,0, 0,3'b111,3'b111,0, 1,1,1));
    tbl.push_back(mk(0,1,'h0F0,3'b000,0,0,0, 0,3'b110,3'b111,0, 2,1,1));
    tbl.push_back(mk(0,1,'h0F0,3'b100,0,0,0, 0,3'b110,3'b111,0, 2,1,1));
    tbl.push_back(mk(0,1,'h0F0,3'b000,0,0,0, 0,3'b010,3'b111,0, 2,1,2));
    tbl.push_back(mk(0,1,'h0F0,3'b010,0,0,0, 1,3'b010,3'b111,0, 2,1,2));
    tbl.push_back(mk(0,1,'h055,3'b001,0,0,0, 0,3'b111,3'b111,0, 2,2,2));
    tbl.push_back(mk(0,1,'h055,3'b000,1,3'b010,0, 0,3'b110,3'b111,0, 3,2,2));
    tbl.push_back(mk(0,1,'h055,3'b000,0,0,0, 0,3'b110,3'b111,1, 3,2,2));
    tbl.push_back(mk(0,1,'h055,3'b110,0,0,0, 1,3'b110,3'b111,1, 3,2,2));
    tbl.push_back(mk(0,1,'h1FF,3'b111,0,0,0, 1,3'b010,3'b010,0, 3,3,3));
    // masked branch
    tbl.push_back(mk(0,0,'h000,3'b000,1,3'b101,0, 0,3'b000,3'b010,0, 3,4,3));
    tbl.push_back(mk(0,1,'h0AA,3'b000,0,0,0, 0,3'b101,3'b101,0, 3,4,3));
    tbl.push_back(mk(0,1,'h0AA,3'b001,0,0,0, 0,3'b101,3'b101,0, 3,4,3));
    tbl.push_back(mk(0,1,'h0AA,3'b100,0,0,0, 1,3'b100,3'b101,0, 4,4,3));
    tbl.push_back(mk(0,1,'h0AB,3'b101,0,0,0, 1,3'b101,3'b101,0, 4,4,4));
    // empty mask drops tokens uncounted
    tbl.push_back(mk(0,0,'h000,3'b000,1,3'b000,0, 0,3'b000,3'b101,0, 5,4,5));
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(0,1,'h1C3,3'b000,0,0,0, 1,3'b000,3'b000,0, 5,4,5));
    tbl.push_back(mk(0,0,'h000,3'b000,1,3'b111,0, 1,3'b000,3'b000,0, 5,4,5));
    // reset mid-token, then clear coinciding with fire
    tbl.push_back(mk(0,1,'h123,3'b100,0,0,0, 0,3'b111,3'b111,0, 5,4,5));
    tbl.push_back(mk(1,1,'h123,3'b000,0,0,0, 0,3'b011,3'b111,0, 5,4,6));
    tbl.push_back(mk(0,1,'h123,3'b000,0,0,0, 0,3'b111,3'b111,0, 0,0,0));
    tbl.push_back(mk(0,1,'h123,3'b111,0,0,0, 1,3'b111,3'b111,0, 0,0,0));
    tbl.push_back(mk(0,1,'h124,3'b111,0,0,1, 1,3'b111,3'b111,0, 1,1,1));
    tbl.push_back(mk(0,0,'h000,3'b000,0,0,0, 0,3'b000,3'b111,0, 0,0,0));

    drive(1, 0, '0, '0, 0, '0, 0);
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      finish_cycle();
    end

    drive(0, 0, '0, '0, 0, '0, 0);
    @(negedge CLK);
    check("rst_active_mask", 64'(active_mask), 64'(3'b111));
    check("rst_cfg_pending", 64'(cfg_pending), 64'(0));
    check("rst_tok_cnt", 64'(tok_cnt), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    finish_cycle();

    foreach (tbl[v]) begin
      drive(tbl[v].rst, tbl[v].iv, tbl[v].dat, tbl[v].rdy, tbl[v].cw, tbl[v].cm, tbl[v].clr);
      @(negedge CLK);
      check($sformatf("vec%0d_in_ready", v), 64'(in_ready), 64'(tbl[v].e_ir));
      check($sformatf("vec%0d_out_valid", v), 64'(out_valid), 64'(tbl[v].e_ov));
      check($sformatf("vec%0d_active_mask", v), 64'(active_mask), 64'(tbl[v].e_am));
      check($sformatf("vec%0d_cfg_pending", v), 64'(cfg_pending), 64'(tbl[v].e_pend));
      for (int i = 0; i < N; i++) begin
        check($sformatf("vec%0d_out_data%0d", v, i), 64'(out_data[i*DW +: DW]), 64'(tbl[v].dat));
        check($sformatf("vec%0d_tok_cnt%0d", v, i), 64'(tok_cnt[i*CW +: CW]), 64'(tbl[v].c[i]));
        check($sformatf("vec%0d_sat_cnt%0d", v, i), 64'(s_tok_cnt[i*SW +: SW]), 64'(sat(tbl[v].c[i], SW)));
      end
      finish_cycle();
    end

    // twenty back-to-back tokens: narrow counters pin at 15
    for (int k = 0; k < 20; k++) begin
      drive(0, 1, DW'(k), 3'b111, 0, '0, 0);
      @(negedge CLK);
      check("sat_run_in_ready", 64'(in_ready), 64'(1));
      finish_cycle();
    end
    drive(0, 0, '0, '0, 0, '0, 0);
    @(negedge CLK);
    check("sat_run_wide_cnt0", 64'(tok_cnt[0 +: CW]), 64'(20));
    check("sat_run_narrow_cnt0", 64'(s_tok_cnt[0 +: SW]), 64'(15));
    finish_cycle();

    for (int k = 0; k < 3000; k++) begin
      logic [N-1:0] eov;
      bit eir;
      drive($urandom_range(0, 299) == 0, $urandom_range(0, 9) != 0, DW'($urandom),
            N'($urandom), $urandom_range(0, 7) == 0, N'($urandom), $urandom_range(0, 399) == 0);
      @(negedge CLK);
      eov = exp_ov();
      eir = exp_ir();
      check("rnd_out_valid", 64'(out_valid), 64'(eov));
      check("rnd_in_ready", 64'(in_ready), 64'(eir));
      check("rnd_active_mask", 64'(active_mask), 64'(m_en));
      check("rnd_cfg_pending", 64'(cfg_pending), 64'(m_pend));
      check("rnd_out_data", 64'(out_data), 64'({N{in_data}}));
      check("rnd_sat_ctrl", 64'({s_in_ready, s_out_valid, s_active_mask, s_cfg_pending}),
            64'({eir, eov, m_en, m_pend}));
      check("rnd_sat_data", 64'(s_out_data), 64'({N{in_data}}));
      for (int i = 0; i < N; i++) begin
        check($sformatf("rnd_tok_cnt%0d", i), 64'(tok_cnt[i*CW +: CW]), 64'(sat(m_cnt[i], CW)));
        check($sformatf("rnd_sat_cnt%0d", i), 64'(s_tok_cnt[i*SW +: SW]), 64'(sat(m_cnt[i], SW)));
      end
      finish_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fanout_fork_ctrl.md
Name: fanout_fork_ctrl

Overview:
- Sequencing controller for a ready/valid broadcast: one upstream producer drives up to NUM_OUT downstream consumers.
- Eager fork: each enabled branch may accept the current token in a different cycle.
- Upstream is acknowledged only once every enabled branch has taken the token.
- Owns the branch-enable configuration: new masks are applied only at token boundaries so no token is split or duplicated.

Parameters:
- NUM_OUT, 3, number of downstream branches (1..8).
- DATA_WIDTH, 17, token payload width.
- CNT_WIDTH, 16, width of the per-branch delivered-token counters.

Ports:
- CLK  in  1  clock.
- RESET  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream token valid.
- in_data  in  DATA_WIDTH  upstream payload.
- in_ready  out  1  upstream acknowledge.
- out_valid  out  NUM_OUT  per-branch valid.
- out_data  out  NUM_OUT*DATA_WIDTH  per-branch payload; every slice equals in_data.
- out_ready  in  NUM_OUT  per-branch ready.
- cfg_wr  in  1  one-cycle strobe that requests a new branch mask.
- cfg_mask  in  NUM_OUT  requested enable mask, sampled when cfg_wr=1.
- cfg_pending  out  1  a requested mask is waiting to be applied.
- active_mask  out  NUM_OUT  mask currently in force.
- cnt_clr  in  1  synchronous clear of all counters.
- tok_cnt  out  NUM_OUT*CNT_WIDTH  per-branch delivered-token counts, saturating.

Behaviour:
- Reset (RESET=1 at a CLK edge) has priority over all other inputs, including a reset asserted mid-token:
  - done=0, active_mask=all-ones, pend_mask=0, cfg_pending=0, tok_cnt=0, state=IDLE.
  - A partially delivered token is abandoned; the producer must re-present it.
- Branch state: done[i] marks that branch i has already accepted the current token.
- Combinational outputs (zero latency, no data register; out_data is wired straight from in_data):
  - out_valid[i] = in_valid & active_mask[i] & ~done[i].
  - in_ready = AND over i of (~active_mask[i] | done[i] | out_ready[i]).
  - active_mask=0 gives in_ready=1: the token is dropped. It is not counted.
- Branch handshake: branch i fires when out_valid[i] & out_ready[i].
- Token completion: a token completes when in_valid & in_ready. On completion:
  - done is cleared to 0, including when the final branch fires in that same cycle.
  - Otherwise done[i] is set to 1 when branch i fires.
  - in_ready=1 with in_valid=0 completes nothing and leaves done unchanged.
- Counters:
  - tok_cnt[i] increments on every fire of branch i and saturates at 2^CNT_WIDTH-1.
  - cnt_clr=1 zeroes all counters. If a fire coincides with cnt_clr, the counter reads 0 afterwards.
- State machine:
  - IDLE (done==0): a cfg_wr in IDLE with in_valid=0 makes active_mask=cfg_mask on the next edge. No pending phase; cfg_pending stays 0.
  - IDLE -> BUSY when in_valid=1, some branch fires, and the token does not complete.
  - BUSY (done!=0) -> IDLE on token completion.
  - cfg_wr while BUSY, or in IDLE with in_valid=1, stores pend_mask=cfg_mask and sets cfg_pending=1.
  - The pending mask loads into active_mask on the edge where the token completes, or on the first IDLE cycle with in_valid=0. cfg_pending then clears.
  - A later cfg_wr overwrites pend_mask; last write wins.
  - cfg_wr coinciding with a load edge: the new cfg_mask wins and is applied immediately.
- in_valid may deassert mid-token only as a protocol error. Behaviour is then defined: done holds, out_valid drops to 0, and delivery resumes when in_valid returns.

Decomposition:
- Shared package fanout_pkg:
  - typedef fork_state_t {IDLE, BUSY}.
  - Localparam defaults for NUM_OUT, DATA_WIDTH, CNT_WIDTH.
  - Function all_accepted(mask, done, ready) implementing the in_ready reduction; the combinational fanout ready logic reuses it.
- One sub-module, fanout_tok_counter: a saturating CNT_WIDTH counter with inc and clr inputs, instantiated NUM_OUT times.

Test Plan:
1. Basic broadcast: mask=3'b111, all out_ready=1, in_valid=1, in_data=0x1A5 -> in_ready=1 in the same cycle, all out_data=0x1A5, each tok_cnt=1, done stays 0.
2. Staggered accept: out_ready pulsed per branch in cycles 0 (b0), 2 (b2) and 4 (b1) -> out_valid goes 111, 110, 110, 010, 010; in_ready=1 only in cycle 4; state returns to IDLE; each tok_cnt=1.
3. Masked branch: mask=3'b101, out_ready[1]=0 held low -> in_ready follows out_ready[0]&out_ready[2]; out_valid[1]=0 throughout; tok_cnt[1] stays 0.
4. Config while BUSY: b0 accepted, then cfg_wr with mask=3'b010 -> cfg_pending=1 and active_mask stays 111 until b1 and b2 accept; on that edge active_mask=010 and cfg_pending=0; the next token goes to b1 only.
5. Empty mask and saturation: mask=0, in_valid=1 for 5 cycles -> in_ready=1 each cycle, all counters unchanged. Separately, with CNT_WIDTH=4, 20 fires on b0 -> tok_cnt[0]=15.
6. Reset mid-token: b2 done, RESET=1 for one cycle -> done=0, active_mask=111, tok_cnt=0; the next cycle re-presents the token on all three branches.
